// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU decode definitions.
// - Default widths: CPU_INSTR_W, CPU_OPC_W, CPU_NUM_REGS, CPU_DATA_W, CPU_RA_W.
// - Field offsets: the flag and register fields are placed above the immediate.
//   BR_OFS, WE_OFS and RD_OFS are measured from bit IMM_W.
//   rs2 sits one RA_W above rd, rs1 one RA_W above rs2, and the op code sits on top.
// - imm_width(): derives the immediate width from the other field widths.
// - decoded_t: one decoded instruction at the default widths.
package cpu_pkg;

   localparam int CPU_INSTR_W  = 32;
   localparam int CPU_OPC_W    = 4;
   localparam int CPU_NUM_REGS = 32;
   localparam int CPU_DATA_W   = 32;
   localparam int CPU_RA_W     = $clog2(CPU_NUM_REGS);

   // Field offsets above the immediate, counted from the LSB upwards.
   localparam int BR_OFS = 0;
   localparam int WE_OFS = 1;
   localparam int RD_OFS = 2;

   function automatic int imm_width(input int instr_w, input int opc_w, input int ra_w);
      return instr_w - opc_w - 3 * ra_w - 2;
   endfunction

   typedef struct packed {
      logic [CPU_OPC_W-1:0]  op_code;
      logic [CPU_RA_W-1:0]   rs1;
      logic [CPU_RA_W-1:0]   rs2;
      logic [CPU_RA_W-1:0]   rd;
      logic                  rd_we;
      logic                  branch_taken;
      logic [CPU_DATA_W-1:0] imm;
   } decoded_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write vector for the decode stage.
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   set_en, set_addr          - a new writer issued; mark its destination pending
//   wb_en, wb_addr            - writeback done; release that register
//   fclr_en, fclr_addr        - a flushed writer; release its destination
//   lk_rs1, lk_rs2, lk_rd     - hazard lookup addresses of the incoming instruction
//   lk_we                     - incoming instruction writes lk_rd
//   hit                       - any looked-up register is pending
module reg_scoreboard
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = CPU_NUM_REGS,
   parameter int RA_W     = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [RA_W-1:0] set_addr,
   input  logic            wb_en,
   input  logic [RA_W-1:0] wb_addr,
   input  logic            fclr_en,
   input  logic [RA_W-1:0] fclr_addr,
   input  logic [RA_W-1:0] lk_rs1,
   input  logic [RA_W-1:0] lk_rs2,
   input  logic [RA_W-1:0] lk_rd,
   input  logic            lk_we,
   output logic            hit
);

   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_d;

   // Clears first, then the set: a new writer is younger than any writeback
   // of the same register in the same cycle, so it must stay pending.
   always_comb begin
      pend_d = pend_q;
      if (wb_en) pend_d[wb_addr] = 1'b0;
      if (fclr_en) pend_d[fclr_addr] = 1'b0;
      if (set_en) pend_d[set_addr] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   // Lookup reads registered state only, so writeback releases a cycle later.
   assign hit = pend_q[lk_rs1] | pend_q[lk_rs2] | (lk_we & pend_q[lk_rd]);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with valid/ready handshake.
// Splits an instruction (MSB first: op code, rs1, rs2, rd, we, branch, imm)
// into fields held in one output register. Define DECODE_SCOREBOARD_EN to
// compile in the RAW/WAW register scoreboard; without it the block is a plain
// one-deep decoder and wb_* are ignored.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   in_instr, in_valid, in_ready      - instruction input handshake
//   out_valid, out_ready              - decoded output handshake
//   op_code, rs1, rs2, rd, rd_we,
//   branch_taken, imm                 - decoded fields (imm sign-extended)
//   wb_valid, wb_addr                 - register writeback release
//   flush                             - discard the held instruction
//   stall                             - input blocked by a hazard
module decode_stage
   import cpu_pkg::*;
#(
   parameter int INSTR_W  = CPU_INSTR_W,
   parameter int OPC_W    = CPU_OPC_W,
   parameter int NUM_REGS = CPU_NUM_REGS,
   parameter int DATA_W   = CPU_DATA_W,
   localparam int RA_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OPC_W-1:0]  op_code,
   output logic [RA_W-1:0]   rs1,
   output logic [RA_W-1:0]   rs2,
   output logic [RA_W-1:0]   rd,
   output logic              rd_we,
   output logic              branch_taken,
   output logic [DATA_W-1:0] imm,
   input  logic              wb_valid,
   input  logic [RA_W-1:0]   wb_addr,
   input  logic              flush,
   output logic              stall
);

   localparam int IMM_W   = imm_width(INSTR_W, OPC_W, RA_W);
   localparam int BR_BIT  = IMM_W + BR_OFS;
   localparam int WE_BIT  = IMM_W + WE_OFS;
   localparam int RD_LSB  = IMM_W + RD_OFS;
   localparam int RS2_LSB = RD_LSB + RA_W;
   localparam int RS1_LSB = RS2_LSB + RA_W;
   localparam int OPC_LSB = RS1_LSB + RA_W;

   generate
      if (IMM_W < 1) begin : g_bad_imm_w
         $error("decode_stage: instruction too narrow, IMM_W must be at least 1");
      end
   endgenerate

   function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [IMM_W-1:0] v);
      return DATA_W'(v);
   endfunction

   // Input decode (combinational)
   logic [OPC_W-1:0]        opc_in;
   logic [RA_W-1:0]         rs1_in, rs2_in, rd_in;
   logic                    we_in, br_in;
   logic signed [IMM_W-1:0] imm_in;

   assign opc_in = in_instr[OPC_LSB +: OPC_W];
   assign rs1_in = in_instr[RS1_LSB +: RA_W];
   assign rs2_in = in_instr[RS2_LSB +: RA_W];
   assign rd_in  = in_instr[RD_LSB +: RA_W];
   assign we_in  = in_instr[WE_BIT];
   assign br_in  = in_instr[BR_BIT];
   assign imm_in = in_instr[IMM_W-1:0];

   logic out_valid_q, out_valid_d;
   logic [OPC_W-1:0] op_code_q, op_code_d;
   logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic rd_we_q, rd_we_d, branch_q, branch_d;
   logic signed [DATA_W-1:0] imm_q, imm_d;

   logic hazard, in_fire, out_fire;

`ifdef DECODE_SCOREBOARD_EN
   logic sb_hit;

   reg_scoreboard #(.NUM_REGS(NUM_REGS), .RA_W(RA_W)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .set_en    (in_fire & we_in & (rd_in != '0)),
      .set_addr  (rd_in),
      .wb_en     (wb_valid),
      .wb_addr   (wb_addr),
      .fclr_en   (flush & out_valid_q & rd_we_q & (rd_q != '0)),
      .fclr_addr (rd_q),
      .lk_rs1    (rs1_in),
      .lk_rs2    (rs2_in),
      .lk_rd     (rd_in),
      .lk_we     (we_in),
      .hit       (sb_hit)
   );

   assign hazard = in_valid & sb_hit;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_valid, wb_addr};
   assign hazard    = 1'b0;
`endif

   assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid_q & out_ready;
   assign stall    = hazard;

   // Output register next state: flush beats the handshake
   always_comb begin
      out_valid_d = out_valid_q;
      op_code_d   = op_code_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      rd_we_d     = rd_we_q;
      branch_d    = branch_q;
      imm_d       = imm_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (in_fire) begin
         out_valid_d = 1'b1;
         op_code_d   = opc_in;
         rs1_d       = rs1_in;
         rs2_d       = rs2_in;
         rd_d        = rd_in;
         rd_we_d     = we_in;
         branch_d    = br_in;
         imm_d       = sext_imm(imm_in);
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         op_code_q   <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rd_we_q     <= 1'b0;
         branch_q    <= 1'b0;
         imm_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         op_code_q   <= op_code_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rd_we_q     <= rd_we_d;
         branch_q    <= branch_d;
         imm_q       <= imm_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign op_code      = op_code_q;
   assign rs1          = rs1_q;
   assign rs2          = rs2_q;
   assign rd           = rd_q;
   assign rd_we        = rd_we_q;
   assign branch_taken = branch_q;
   assign imm          = imm_q;

endmodule
